// File: rtl/fpu_issue_ctrl.sv
// Request-side initiator for the FP unit: queues operations, issues one at a time,
// guards each against a unit that never finishes, and returns result plus tag in order.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_funct,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic             fpu_finish,
  input  logic [31:0]      fpu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [1:0]        funct;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  timer;
  state_t            state;
  state_t            state_nxt;
  logic              push;
  logic              pop;
  logic              capture;
  logic              expire;
  logic              timer_hit;

  // Ready comes from the registered count only, so a same-cycle pop never opens a full FIFO.
  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign timer_hit = (timer == TMR_LAST);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{funct: req_funct, a: req_a, b: req_b, tag: req_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ARM only advances on a sampled-low finish so a level left over from the previous op is ignored.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE: if (count != '0) state_nxt = S_ARM;
      S_ARM: begin
        if (timer_hit) begin
          expire    = 1'b1;
          state_nxt = S_RESP;
        end else if (!fpu_finish) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_finish) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (timer_hit) begin
          expire    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_funct   <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      rsp_result  <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      if (pop) begin
        fpu_funct <= mem[rd_ptr].funct;
        fpu_a     <= mem[rd_ptr].a;
        fpu_b     <= mem[rd_ptr].b;
        rsp_tag   <= mem[rd_ptr].tag;
        timer     <= '0;
      end else if (state == S_ARM || state == S_WAIT) begin
        timer <= timer + 1'b1;
      end
      if (capture) begin
        rsp_result  <= fpu_o;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_result  <= QNAN;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: the bench plays both the client and the FP unit.
module tb_fpu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_funct = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [1:0]       fpu_funct;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_finish = 1'b0;
  logic [31:0]      fpu_o = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_finish(fpu_finish), .fpu_o(fpu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b; req_tag = t;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic seen;
    rst = 1'b1;
    tick; tick;
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL reset_hold: ready/busy/valid=%b required 100", {req_ready, busy, rsp_valid});
    end
    rst = 1'b0;
    push_one(2'd2, 32'h1111_1111, 32'h2222_2222, 4'd3);
    push_one(2'd1, 32'h3333_3333, 32'h4444_4444, 4'd4);
    n_checks++;
    if (fpu_a !== 32'h1111_1111 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_prep_issue: fpu_a=%h busy=%b required 11111111 1", fpu_a, busy);
    end
    tick;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({fpu_funct, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_tag, rsp_timeout, busy, req_ready} !==
        {2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_async: funct=%h a=%h b=%h v=%b r=%h t=%h to=%b busy=%b ready=%b required zeros ready=1",
                         fpu_funct, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_tag, rsp_timeout, busy, req_ready);
    end
    tick;
    rst = 1'b0;
    fpu_finish = 1'b1; fpu_o = 32'hDEAD_BEEF;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      fpu_finish = ~fpu_finish;
      if (rsp_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: activity after reset=%b required 0", seen);
    end
    fpu_finish = 1'b0;
  endtask

  task automatic test_min_latency;
    fpu_finish = 1'b0;
    push_one(2'd0, 32'h4000_0000, 32'h4000_0000, 4'd1);
    tick;
    tick;
    fpu_finish = 1'b1; fpu_o = 32'h4080_0000;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: rsp_valid=%b after E2 required 0", rsp_valid);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h4080_0000 || rsp_tag !== 4'd1) begin
      n_fail++; $display("FAIL latency_e3: valid=%b result=%h tag=%h required 1 40800000 1", rsp_valid, rsp_result, rsp_tag);
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    fpu_finish = 1'b0;
  endtask

  task automatic test_add;
    int waited;
    fpu_finish = 1'b1; fpu_o = 32'h0BAD_0BAD;
    push_one(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5);
    tick;
    fpu_finish = 1'b0;
    n_checks++;
    if ({fpu_funct, fpu_a, fpu_b} !== {2'd0, 32'h3F80_0000, 32'h4000_0000}) begin
      n_fail++; $display("FAIL add_issue: funct=%h a=%h b=%h required 0 3f800000 40000000", fpu_funct, fpu_a, fpu_b);
    end
    for (int k = 0; k < 5; k++) tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_no_early_rsp: rsp_valid=%b required 0", rsp_valid);
    end
    fpu_finish = 1'b1; fpu_o = 32'h4040_0000;
    waited = 0;
    while (!rsp_valid && waited < 10) begin tick; waited++; end
    n_checks++;
    if (rsp_valid !== 1'b1 || waited != 1) begin
      n_fail++; $display("FAIL add_rsp_wait: valid=%b cycles=%0d required 1 1", rsp_valid, waited);
    end
    n_checks++;
    if ({rsp_result, rsp_tag, rsp_timeout} !== {32'h4040_0000, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL add_rsp: result=%h tag=%h timeout=%b required 40400000 5 0", rsp_result, rsp_tag, rsp_timeout);
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_done: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    fpu_finish = 1'b0;
  endtask

  task automatic test_stale_finish;
    fpu_finish = 1'b1; fpu_o = 32'hDEAD_BEEF;
    push_one(2'd3, 32'h4000_0000, 32'h4040_0000, 4'd3);
    tick; tick; tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_rejected: rsp_valid=%b with stale finish required 0", rsp_valid);
    end
    fpu_finish = 1'b0;
    tick; tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_low: rsp_valid=%b required 0", rsp_valid);
    end
    fpu_finish = 1'b1; fpu_o = 32'h40C0_0000;
    tick;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_timeout, fpu_funct} !== {1'b1, 32'h40C0_0000, 4'd3, 1'b0, 2'd3}) begin
      n_fail++; $display("FAIL stale_mul_rsp: v=%b result=%h tag=%h to=%b funct=%h required 1 40c00000 3 0 3",
                         rsp_valid, rsp_result, rsp_tag, rsp_timeout, fpu_funct);
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    fpu_finish = 1'b0;
  endtask

  task automatic test_timeout;
    fpu_finish = 1'b0;
    req_valid = 1'b1; req_funct = 2'd2; req_a = 32'h4120_0000; req_b = 32'h0000_0000; req_tag = 4'd7;
    tick;
    req_funct = 2'd0; req_a = 32'h4120_0000; req_b = 32'h3F80_0000; req_tag = 4'd8;
    tick;
    req_valid = 1'b0;
    n_checks++;
    if ({fpu_funct, fpu_b} !== {2'd2, 32'h0}) begin
      n_fail++; $display("FAIL to_issue: funct=%h b=%h required 2 00000000", fpu_funct, fpu_b);
    end
    for (int k = 0; k < TIMEOUT - 1; k++) tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_early: rsp_valid=%b one cycle before timeout required 0", rsp_valid);
    end
    tick;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_timeout} !== {1'b1, 32'h7FC0_0000, 4'd7, 1'b1}) begin
      n_fail++; $display("FAIL to_rsp: v=%b result=%h tag=%h to=%b required 1 7fc00000 7 1",
                         rsp_valid, rsp_result, rsp_tag, rsp_timeout);
    end
    tick; tick;
    n_checks++;
    if ({rsp_valid, rsp_result, fpu_funct} !== {1'b1, 32'h7FC0_0000, 2'd2}) begin
      n_fail++; $display("FAIL to_hold: v=%b result=%h funct=%h required 1 7fc00000 2", rsp_valid, rsp_result, fpu_funct);
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || fpu_b !== 32'h0) begin
      n_fail++; $display("FAIL to_accept: v=%b fpu_b=%h required 0 00000000", rsp_valid, fpu_b);
    end
    tick;
    n_checks++;
    if ({fpu_funct, fpu_a, fpu_b} !== {2'd0, 32'h4120_0000, 32'h3F80_0000}) begin
      n_fail++; $display("FAIL to_next_issue: funct=%h a=%h b=%h required 0 41200000 3f800000", fpu_funct, fpu_a, fpu_b);
    end
    tick;
    fpu_finish = 1'b1; fpu_o = 32'h4130_0000;
    tick;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_timeout} !== {1'b1, 32'h4130_0000, 4'd8, 1'b0}) begin
      n_fail++; $display("FAIL to_next_rsp: v=%b result=%h tag=%h to=%b required 1 41300000 8 0",
                         rsp_valid, rsp_result, rsp_tag, rsp_timeout);
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    fpu_finish = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_tab [5];
    logic [31:0] b_tab [5];
    logic [31:0] exp_tab [5];
    int accepted;
    logic leak;
    int waited;
    for (int i = 0; i < 5; i++) begin
      a_tab[i]   = 32'h3F80_0000 + 32'(i);
      b_tab[i]   = 32'h0000_0100 * 32'(i);
      exp_tab[i] = 32'h3F80_0000 + 32'(i) + 32'h0000_0100 * 32'(i);
    end
    fpu_finish = 1'b0; rsp_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 20 && accepted < 5; k++) begin
      req_valid = 1'b1; req_funct = 2'd0; req_tag = TAG_W'(accepted);
      req_a = a_tab[accepted]; req_b = b_tab[accepted];
      if (req_ready) begin tick; accepted++; end
      else tick;
    end
    req_valid = 1'b0;
    n_checks++;
    if (accepted != 5 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_fill: accepted=%0d ready=%b required 5 0", accepted, req_ready);
    end
    leak = 1'b0;
    req_valid = 1'b1; req_tag = 4'd9; req_a = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      if (req_ready) leak = 1'b1;
      tick;
    end
    req_valid = 1'b0;
    n_checks++;
    if (leak !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full_ready: ready seen while full=%b required 0", leak);
    end
    for (int i = 0; i < 5; i++) begin
      fpu_finish = 1'b0; tick;
      fpu_finish = 1'b1; fpu_o = fpu_a + fpu_b; tick;
      waited = 0;
      while (!rsp_valid && waited < 80) begin tick; waited++; end
      n_checks++;
      if ({rsp_valid, rsp_tag, rsp_result, rsp_timeout} !== {1'b1, TAG_W'(i), exp_tab[i], 1'b0}) begin
        n_fail++; $display("FAIL b2b_order[%0d]: v=%b tag=%h result=%h to=%b required 1 %h %h 0",
                           i, rsp_valid, rsp_tag, rsp_result, rsp_timeout, TAG_W'(i), exp_tab[i]);
      end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      fpu_finish = 1'b0; tick;
    end
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_drained: busy=%b ready=%b required 0 1", busy, req_ready);
    end
  endtask

  task automatic test_rsp_backpressure;
    logic [TAG_W-1:0] tag_tab [3];
    logic [31:0]      exp_tab [3];
    logic [7:0]       rdy_pat;
    logic             pv, pr;
    logic [31:0]      presult;
    logic [TAG_W-1:0] ptag;
    int got;
    rdy_pat = 8'b1010_0110;
    fpu_finish = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tag_tab[i] = TAG_W'(10 + i);
      exp_tab[i] = 32'h4000_0000 + 32'h0010_0000 * 32'(i + 1) + 32'(i);
      push_one(2'd1, 32'h4000_0000 + 32'h0010_0000 * 32'(i + 1), 32'(i), tag_tab[i]);
    end
    got = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      rsp_ready  = rdy_pat[cyc % 8];
      fpu_finish = (cyc % 3 == 2);
      fpu_o      = fpu_a + fpu_b;
      pv = rsp_valid; pr = rsp_ready; presult = rsp_result; ptag = rsp_tag;
      if (pv && pr) begin
        n_checks++;
        if (got >= 3) begin
          n_fail++; $display("FAIL bp_extra: extra response tag=%h required none", ptag);
        end else if ({ptag, presult} !== {tag_tab[got], exp_tab[got]}) begin
          n_fail++; $display("FAIL bp_rsp[%0d]: tag=%h result=%h required %h %h", got, ptag, presult, tag_tab[got], exp_tab[got]);
        end
        got++;
      end
      tick;
      if (pv && !pr) begin
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, presult, ptag}) begin
          n_fail++; $display("FAIL bp_stable: v=%b result=%h tag=%h required 1 %h %h", rsp_valid, rsp_result, rsp_tag, presult, ptag);
        end
      end
    end
    rsp_ready = 1'b0; fpu_finish = 1'b0;
    n_checks++;
    if (got != 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: responses=%0d busy=%b required 3 0", got, busy);
    end
  endtask

  initial begin
    test_reset;
    test_min_latency;
    test_add;
    test_stale_finish;
    test_timeout;
    test_back_to_back;
    test_rsp_backpressure;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
